// File: rtl/ucsbece154b_bp_update_ctrl.sv
// Branch-predictor update controller: tracks fetch-time predictions in order, resolves them
// against Execute, trains the BTB/PHT and issues redirect/flush on mispredicts.
//
//   state   | meaning
//   RUN     | accept fetch records, retire on e_valid_i, train predictor
//   FLUSH   | wrong-path drain after a redirect; fetch stalled, Execute ignored
module ucsbece154b_bp_update_ctrl #(
   parameter int NUM_BTB_ENTRIES = 32,
   parameter int NUM_GHR_BITS    = 5,
   parameter int Q_DEPTH         = 4,
   parameter int FLUSH_CYCLES    = 2
) (
   input  logic                               clk,
   input  logic                               reset_i,
   input  logic                               f_valid_i,
   input  logic [31:0]                        f_pc_i,
   input  logic                               f_pred_taken_i,
   input  logic [31:0]                        f_pred_target_i,
   input  logic [NUM_GHR_BITS-1:0]            f_pht_addr_i,
   output logic                               f_ready_o,
   input  logic                               e_valid_i,
   input  logic [31:0]                        e_pc_i,
   input  logic [6:0]                         e_op_i,
   input  logic                               e_taken_i,
   input  logic [31:0]                        e_target_i,
   output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
   output logic [31:0]                        BTBwritedata_o,
   output logic                               BTB_we_o,
   output logic                               PHTwe_o,
   output logic                               PHTincrement_o,
   output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
   output logic [6:0]                         op_o,
   output logic                               GHRreset_o,
   output logic                               mispredict_o,
   output logic [31:0]                        redirect_pc_o,
   output logic [$clog2(Q_DEPTH):0]           q_count_o,
   output logic                               err_o
);

   localparam int IDX = $clog2(NUM_BTB_ENTRIES);
   localparam int QW  = $clog2(Q_DEPTH);
   localparam int CW  = QW + 1;
   localparam int FW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [0:0] S_RUN   = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [31:0]             q_pc     [Q_DEPTH];
   logic                    q_taken  [Q_DEPTH];
   logic [31:0]             q_target [Q_DEPTH];
   logic [NUM_GHR_BITS-1:0] q_pht    [Q_DEPTH];

   logic [0:0]    state;
   logic [FW-1:0] flush_cnt;
   logic [QW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic full, empty, in_run, push, pop, pop_ok, pop_err;
   logic is_branch, is_ctrl, pred_taken, wrong_pred, mispredict;
   logic [31:0] pred_target, redirect_pc;

   assign full   = (count == CW'(Q_DEPTH));
   assign empty  = (count == '0);
   assign in_run = (state == S_RUN);

   // A same-cycle retire frees the slot the incoming record needs.
   assign f_ready_o = !reset_i && in_run && (!full || e_valid_i);
   assign push      = f_valid_i && f_ready_o;
   assign pop       = e_valid_i && in_run;

   assign pred_taken  = q_taken[rd_ptr];
   assign pred_target = q_target[rd_ptr];

   assign pop_ok  = pop && !empty && (q_pc[rd_ptr] == e_pc_i);
   assign pop_err = pop && !pop_ok;

   assign is_branch = (e_op_i == OP_BRANCH);
   assign is_ctrl   = is_branch || (e_op_i == OP_JAL) || (e_op_i == OP_JALR);

   assign wrong_pred = is_ctrl ? ((pred_taken != e_taken_i) ||
                                  (e_taken_i && (pred_target != e_target_i)))
                               : pred_taken;
   assign mispredict  = pop_err || (pop_ok && wrong_pred);
   assign redirect_pc = e_taken_i ? e_target_i : (e_pc_i + 32'd4);

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]     <= f_pc_i;
         q_taken[wr_ptr]  <= f_pred_taken_i;
         q_target[wr_ptr] <= f_pred_target_i;
         q_pht[wr_ptr]    <= f_pht_addr_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state             <= S_RUN;
         flush_cnt         <= '0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         err_o             <= 1'b0;
         mispredict_o      <= 1'b0;
         GHRreset_o        <= 1'b0;
         redirect_pc_o     <= '0;
         op_o              <= '0;
         BTB_we_o          <= 1'b0;
         BTBwriteaddress_o <= '0;
         BTBwritedata_o    <= '0;
         PHTwe_o           <= 1'b0;
         PHTincrement_o    <= 1'b0;
         PHTwriteaddress_o <= '0;
      end else begin
         if (mispredict) begin
            state     <= S_FLUSH;
            flush_cnt <= FW'(FLUSH_CYCLES - 1);
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
         end else if (state == S_FLUSH) begin
            if (flush_cnt == '0) state <= S_RUN;
            else                 flush_cnt <= flush_cnt - FW'(1);
         end else begin
            if (push)   wr_ptr <= wr_ptr + QW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + QW'(1);
            case ({push, pop_ok})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end

         if (pop_err) err_o <= 1'b1;

         mispredict_o      <= mispredict;
         GHRreset_o        <= mispredict;
         redirect_pc_o     <= mispredict ? redirect_pc : '0;
         op_o              <= pop_ok ? e_op_i : '0;
         BTB_we_o          <= pop_ok && is_ctrl && e_taken_i &&
                              ((pred_target == '0) || (pred_target != e_target_i));
         BTBwriteaddress_o <= pop_ok ? e_pc_i[IDX+1:2] : '0;
         BTBwritedata_o    <= pop_ok ? e_target_i : '0;
         PHTwe_o           <= pop_ok && is_branch;
         PHTincrement_o    <= pop_ok && e_taken_i;
         PHTwriteaddress_o <= pop_ok ? q_pht[rd_ptr] : '0;
      end
   end

   assign q_count_o = count;

endmodule
